// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive controller slice.
//   - I/O port addresses decoded by uart_rx_ctrl
//   - bit positions inside the STATUS byte
//   - receiver configuration layout and its reset value
//   - state encodings for the config-deferral and interrupt FSMs
package uart_pkg;

  // Port addresses on the PicoBlaze-style I/O bus
  localparam logic [3:0] PORT_DATA = 4'd0;
  localparam logic [3:0] PORT_STAT = 4'd1;
  localparam logic [3:0] PORT_CFG  = 4'd2;
  localparam logic [3:0] PORT_IE   = 4'd3;

  // STATUS byte bit indices
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_PERR      = 3;
  localparam int ST_FERR      = 4;
  localparam int ST_CFG_PEND  = 5;

  // Reset configuration
  localparam logic [3:0] CFG_BAUD_RST  = 4'b1000;
  localparam logic       CFG_EIGHT_RST = 1'b1;
  localparam logic       CFG_PEN_RST   = 1'b0;
  localparam logic       CFG_OHEL_RST  = 1'b0;

  // Field order matches the CPU write layout out_port[6:0]
  typedef struct packed {
    logic       ohel;
    logic       pen;
    logic       eight;
    logic [3:0] baud;
  } rx_cfg_t;

  localparam rx_cfg_t CFG_RST = '{ohel: CFG_OHEL_RST, pen: CFG_PEN_RST,
                                  eight: CFG_EIGHT_RST, baud: CFG_BAUD_RST};

  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_e;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_ASSERT, IRQ_WAIT} irq_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO for received characters.
//   CLK, RESET : clock, asynchronous active-high reset
//   push_i     : write data_i (ignored when full unless a pop happens too)
//   pop_i      : discard head entry (ignored when empty)
//   head_o     : current head byte, combinational from the read pointer
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// Overflow bookkeeping is left to the caller.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: glue between the UART receive engine and the CPU I/O port bus.
//   CLK, RESET                      : clock, asynchronous active-high reset
//   port_id, out_port, write_strobe,
//   read_strobe, in_port            : CPU port bus (in_port is combinational)
//   INTERRUPT, interrupt_ack        : level interrupt and its acknowledge
//   rx_done, rx_data, rx_perr,
//   rx_ferr, rx_busy                : receive engine handshake
//   BAUD, EIGHT, PEN, OHEL          : receiver configuration to the engine
// Config writes made while the engine is mid-frame are held in a shadow
// register and applied on the first idle cycle, so the engine never sees
// its configuration change under a frame.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       INTERRUPT,
  input  logic       interrupt_ack,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_perr,
  input  logic       rx_ferr,
  input  logic       rx_busy,
  output logic [3:0] BAUD,
  output logic       EIGHT,
  output logic       PEN,
  output logic       OHEL
);

  cfg_state_e cfg_state_q, cfg_state_d;
  irq_state_e irq_state_q, irq_state_d;
  rx_cfg_t    cfg_q, cfg_d, shadow_q, shadow_d;
  logic [1:0] ie_q, ie_d;
  logic       ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic       int_q;

  logic       rd_data, rd_stat, wr_cfg, wr_ie, pop_eff, cause;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head, status;
  logic       unused_bits;

  assign unused_bits = out_port[7];

  assign rd_data = read_strobe  && (port_id == PORT_DATA);
  assign rd_stat = read_strobe  && (port_id == PORT_STAT);
  assign wr_cfg  = write_strobe && (port_id == PORT_CFG);
  assign wr_ie   = write_strobe && (port_id == PORT_IE);
  assign pop_eff = rd_data & ~fifo_empty;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (rx_done),
    .data_i  (rx_data),
    .pop_i   (rd_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky flags: clear-on-read first, then any set wins.
  assign ovf_d  = (ovf_q  & ~rd_stat) | (rx_done & fifo_full & ~pop_eff);
  assign perr_d = (perr_q & ~rd_stat) | (rx_done & rx_perr);
  assign ferr_d = (ferr_q & ~rd_stat) | (rx_done & rx_ferr);
  assign ie_d   = wr_ie ? out_port[1:0] : ie_q;

  always_comb begin
    status = 8'h00;
    status[ST_NOT_EMPTY] = ~fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVF]       = ovf_q;
    status[ST_PERR]      = perr_q;
    status[ST_FERR]      = ferr_q;
    status[ST_CFG_PEND]  = (cfg_state_q == CFG_PEND);
  end

  always_comb begin
    in_port = 8'h00;
    case (port_id)
      PORT_DATA: in_port = fifo_empty ? 8'h00 : fifo_head;
      PORT_STAT: in_port = status;
      PORT_IE:   in_port = {6'b0, ie_q};
      default:   in_port = 8'h00;
    endcase
  end

  // Config deferral FSM
  always_comb begin
    cfg_state_d = cfg_state_q;
    cfg_d       = cfg_q;
    shadow_d    = shadow_q;
    case (cfg_state_q)
      CFG_IDLE: begin
        if (wr_cfg) begin
          if (rx_busy) begin
            shadow_d    = rx_cfg_t'(out_port[6:0]);
            cfg_state_d = CFG_PEND;
          end else begin
            cfg_d = rx_cfg_t'(out_port[6:0]);
          end
        end
      end
      CFG_PEND: begin
        if (wr_cfg) shadow_d = rx_cfg_t'(out_port[6:0]);
        if (!rx_busy) begin
          // A write landing on the release cycle is the latest one, so it wins.
          cfg_d       = wr_cfg ? rx_cfg_t'(out_port[6:0]) : shadow_q;
          cfg_state_d = CFG_IDLE;
        end
      end
      default: cfg_state_d = CFG_IDLE;
    endcase
  end

  // Interrupt FSM
  assign cause = (ie_q[0] & ~fifo_empty) | (ie_q[1] & (ovf_q | perr_q | ferr_q));

  always_comb begin
    irq_state_d = irq_state_q;
    case (irq_state_q)
      IRQ_IDLE:   if (cause) irq_state_d = IRQ_ASSERT;
      IRQ_ASSERT: if (interrupt_ack) irq_state_d = IRQ_WAIT;
      IRQ_WAIT: begin
        // After an ack, only a fresh frame re-raises a still-pending cause.
        if (!cause)       irq_state_d = IRQ_IDLE;
        else if (rx_done) irq_state_d = IRQ_ASSERT;
      end
      default: irq_state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cfg_state_q <= CFG_IDLE;
      irq_state_q <= IRQ_IDLE;
      cfg_q       <= CFG_RST;
      shadow_q    <= CFG_RST;
      ie_q        <= 2'b00;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      cfg_state_q <= cfg_state_d;
      irq_state_q <= irq_state_d;
      cfg_q       <= cfg_d;
      shadow_q    <= shadow_d;
      ie_q        <= ie_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      int_q       <= (irq_state_d == IRQ_ASSERT);
    end
  end

  assign INTERRUPT = int_q;
  assign BAUD      = cfg_q.baud;
  assign EIGHT     = cfg_q.eight;
  assign PEN       = cfg_q.pen;
  assign OHEL      = cfg_q.ohel;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scenarios followed by a randomized phase, all
// compared against a queue-based reference model of the controller.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe, read_strobe;
  logic [7:0] in_port;
  logic       INTERRUPT, interrupt_ack;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_busy;
  logic [3:0] BAUD;
  logic       EIGHT, PEN, OHEL;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DEPTH(8), .AW(3)) dut (
    .CLK(CLK), .RESET(RESET), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .INTERRUPT(INTERRUPT), .interrupt_ack(interrupt_ack),
    .rx_done(rx_done), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_busy(rx_busy), .BAUD(BAUD), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL)
  );

  // Reference model: byte queue, sticky flags, requested vs. applied config.
  logic [7:0] mq[$];
  bit         m_ovf, m_perr, m_ferr, m_pend;
  logic [6:0] m_cfg, m_want;
  logic [1:0] m_ie;
  logic [7:0] last_rd;
  bit         busy_g;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {2'b00, m_pend, m_ferr, m_perr, m_ovf,
            (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] p);
    case (p)
      4'd0:    return (mq.size() != 0) ? mq[0] : 8'h00;
      4'd1:    return m_status();
      4'd3:    return {6'b0, m_ie};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_edge(input bit busy, input bit done, input logic [7:0] d,
                        input bit pe, input bit fe, input logic [3:0] p,
                        input bit rd, input bit wr, input logic [7:0] wd);
    if (rd && p == 4'd0 && mq.size() != 0) void'(mq.pop_front());
    if (rd && p == 4'd1) begin m_ovf = 0; m_perr = 0; m_ferr = 0; end
    if (done) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
      if (pe) m_perr = 1;
      if (fe) m_ferr = 1;
    end
    if (wr && p == 4'd2) begin m_want = wd[6:0]; m_pend = 1; end
    if (wr && p == 4'd3) m_ie = wd[1:0];
    // The most recent config request takes effect on any edge with the engine idle.
    if (m_pend && !busy) begin m_cfg = m_want; m_pend = 0; end
  endtask

  // One bus/engine cycle, entered and left at posedge+1.
  task automatic cycle(input bit busy, input bit done, input logic [7:0] d,
                       input bit pe, input bit fe, input logic [3:0] p,
                       input bit rd, input bit wr, input logic [7:0] wd, input bit ack);
    rx_busy = busy; rx_done = done; rx_data = d; rx_perr = pe; rx_ferr = fe;
    port_id = p; read_strobe = rd; write_strobe = wr; out_port = wd; interrupt_ack = ack;
    #1;
    last_rd = in_port;
    if (!wr) chk($sformatf("in_port_p%0d", p), in_port, m_read(p));
    @(posedge CLK);
    m_edge(busy, done, d, pe, fe, p, rd, wr, wd);
    #1;
    rx_done = 0; read_strobe = 0; write_strobe = 0; interrupt_ack = 0;
    chk("cfg_out", {1'b0, OHEL, PEN, EIGHT, BAUD}, {1'b0, m_cfg});
  endtask

  task automatic idle(input logic [3:0] p);
    cycle(busy_g, 0, 8'h00, 0, 0, p, 0, 0, 8'h00, 0);
  endtask
  task automatic push(input logic [7:0] d, input bit pe, input bit fe);
    cycle(busy_g, 1, d, pe, fe, 4'd1, 0, 0, 8'h00, 0);
  endtask
  task automatic rd(input logic [3:0] p);
    cycle(busy_g, 0, 8'h00, 0, 0, p, 1, 0, 8'h00, 0);
  endtask
  task automatic wr(input logic [3:0] p, input logic [7:0] v);
    cycle(busy_g, 0, 8'h00, 0, 0, p, 0, 1, v, 0);
  endtask
  task automatic ack();
    cycle(busy_g, 0, 8'h00, 0, 0, 4'd1, 0, 0, 8'h00, 1);
  endtask

  initial begin
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_pend = 0;
    m_cfg = 7'h18; m_want = 7'h18; m_ie = 2'b00; busy_g = 0;
    RESET = 1; port_id = 0; out_port = 0; write_strobe = 0; read_strobe = 0;
    interrupt_ack = 0; rx_done = 0; rx_data = 0; rx_perr = 0; rx_ferr = 0; rx_busy = 0;
    repeat (3) @(posedge CLK);
    #1 RESET = 0;

    // Reset state
    idle(4'd1); chk("rst_stat", last_rd, 8'h00);
    idle(4'd2); chk("rst_p2", last_rd, 8'h00);
    idle(4'd3); chk("rst_ie", last_rd, 8'h00);
    chk("rst_baud", {4'b0, BAUD}, 8'h08);
    chk("rst_flags", {5'b0, EIGHT, PEN, OHEL}, 8'h04);
    chk("rst_int", {7'b0, INTERRUPT}, 8'h00);

    // Deferred config write
    busy_g = 1;
    wr(4'd2, 8'h65);
    repeat (19) idle(4'd1);
    chk("pend_stat", last_rd, 8'h20);
    chk("pend_baud", {4'b0, BAUD}, 8'h08);
    busy_g = 0;
    idle(4'd1);
    chk("cfg_baud", {4'b0, BAUD}, 8'h05);
    chk("cfg_flags", {5'b0, EIGHT, PEN, OHEL}, 8'h03);
    idle(4'd1); chk("cfg_pend_clr", last_rd, 8'h00);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 0, 0);
    push(8'hAA, 0, 0);
    idle(4'd1); chk("full_ovf_stat", last_rd, 8'h07);
    for (int i = 0; i < 8; i++) begin rd(4'd0); chk("pop", last_rd, 8'(8'h10 + i)); end
    rd(4'd0); chk("empty_rd", last_rd, 8'h00);
    rd(4'd1); chk("ovf_stat", last_rd, 8'h04);
    idle(4'd1); chk("ovf_clr", last_rd, 8'h00);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i), 0, 0);
    cycle(0, 1, 8'h5A, 0, 0, 4'd0, 1, 0, 8'h00, 0);
    chk("simul_rd", last_rd, 8'h20);
    idle(4'd1); chk("simul_stat", last_rd, 8'h03);
    for (int i = 1; i < 8; i++) begin rd(4'd0); chk("simul_pop", last_rd, 8'(8'h20 + i)); end
    rd(4'd0); chk("simul_last", last_rd, 8'h5A);
    idle(4'd1); chk("simul_empty", last_rd, 8'h00);

    // Error interrupt with acknowledge
    wr(4'd3, 8'h02);
    push(8'h33, 0, 1);
    chk("irq_early", {7'b0, INTERRUPT}, 8'h00);
    idle(4'd1); idle(4'd1);
    chk("irq_err_set", {7'b0, INTERRUPT}, 8'h01);
    repeat (3) idle(4'd1);
    chk("irq_hold", {7'b0, INTERRUPT}, 8'h01);
    ack();
    chk("irq_ack_low", {7'b0, INTERRUPT}, 8'h00);
    idle(4'd1); chk("irq_wait_low", {7'b0, INTERRUPT}, 8'h00);
    rd(4'd1); chk("ferr_stat", last_rd, 8'h11);
    idle(4'd1); idle(4'd1);
    chk("irq_after_clr", {7'b0, INTERRUPT}, 8'h00);
    // Back in idle, a standing data cause raises the line without a new frame.
    wr(4'd3, 8'h01);
    idle(4'd1); idle(4'd1);
    chk("irq_idle_reassert", {7'b0, INTERRUPT}, 8'h01);
    ack();
    rd(4'd0); chk("irq_byte", last_rd, 8'h33);
    idle(4'd1); idle(4'd1);
    chk("irq_empty_low", {7'b0, INTERRUPT}, 8'h00);

    // Data interrupt re-raised by a second frame after an ack
    push(8'h41, 0, 0);
    idle(4'd1); idle(4'd1);
    chk("irq_data", {7'b0, INTERRUPT}, 8'h01);
    ack();
    idle(4'd1); chk("irq_data_wait", {7'b0, INTERRUPT}, 8'h00);
    push(8'h42, 0, 0);
    idle(4'd1); chk("irq_data_reassert", {7'b0, INTERRUPT}, 8'h01);
    ack();
    rd(4'd0); chk("data_b1", last_rd, 8'h41);
    rd(4'd0); chk("data_b2", last_rd, 8'h42);
    wr(4'd3, 8'h00);
    idle(4'd1); idle(4'd1);
    chk("irq_off", {7'b0, INTERRUPT}, 8'h00);

    // Randomized traffic against the model (interrupts disabled)
    for (int i = 0; i < 500; i++) begin
      int op;
      bit done, pe, fe;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) busy_g = ~busy_g;
      done = ($urandom_range(0, 1) == 0);
      d    = 8'($urandom);
      pe   = ($urandom_range(0, 7) == 0);
      fe   = ($urandom_range(0, 7) == 0);
      op   = $urandom_range(0, 9);
      case (op)
        0, 1, 2: cycle(busy_g, done, d, pe, fe, 4'd0, 1, 0, 8'h00, 0);
        3:       cycle(busy_g, done, d, pe, fe, 4'd1, 1, 0, 8'h00, 0);
        4:       cycle(busy_g, done, d, pe, fe, 4'd2, 0, 1, 8'($urandom), 0);
        5:       cycle(busy_g, done, d, pe, fe, 4'd3, 1, 0, 8'h00, 0);
        6:       cycle(busy_g, done, d, pe, fe, 4'($urandom_range(4, 15)), 0, 1, 8'($urandom), 0);
        default: cycle(busy_g, done, d, pe, fe, 4'($urandom_range(0, 15)), 0, 0, 8'h00, 0);
      endcase
      chk("rand_int", {7'b0, INTERRUPT}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller between the UART receive engine and the PicoBlaze-style I/O port bus. It owns the receiver configuration register (BAUD/EIGHT/PEN/OHEL) and defers configuration changes until the engine is idle. It buffers completed bytes in a FIFO, keeps sticky error status, and raises a level interrupt with an acknowledge handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
AW, 3, FIFO pointer width; AW = log2(DEPTH).

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
port_id  in  4  bus port address
out_port  in  8  CPU write data
write_strobe  in  1  one-cycle write qualifier
read_strobe  in  1  one-cycle read qualifier
in_port  out  8  CPU read data; combinational from port_id
INTERRUPT  out  1  level interrupt to CPU
interrupt_ack  in  1  one-cycle acknowledge from CPU
rx_done  in  1  engine frame-complete pulse (one cycle)
rx_data  in  8  engine received byte; valid with rx_done
rx_perr  in  1  parity error for the frame; valid with rx_done
rx_ferr  in  1  framing error for the frame; valid with rx_done
rx_busy  in  1  high while the engine is mid-frame
BAUD  out  4  baud code to engine
EIGHT  out  1  8-bit data select
PEN  out  1  parity enable
OHEL  out  1  odd(1)/even(0) parity

Behaviour:
- Reset is RESET, asynchronous, active-high; clock is CLK. All state is posedge CLK.
- Reset values: BAUD=4'b1000, EIGHT=1, PEN=0, OHEL=0, FIFO empty, all sticky flags 0, IE=2'b00, INTERRUPT=0, cfg FSM in CFG_IDLE.
- Port map:
  - Port 0, read: FIFO head byte; read_strobe pops it. If the FIFO is empty, reads 8'h00 and nothing pops.
  - Port 1, read: STATUS = {2'b0, cfg_pend, ferr, perr, ovf, full, not_empty}. read_strobe clears ovf/perr/ferr on the same edge.
  - Port 2, write: config; out_port[3:0]=BAUD, [4]=EIGHT, [5]=PEN, [6]=OHEL.
  - Port 3, write: IE = out_port[1:0]; bit0 = data interrupt, bit1 = error interrupt.
  - Port 3, read: {6'b0, IE}.
  - Other ports: read 8'h00; writes are ignored.
- Config FSM, states CFG_IDLE and CFG_PEND:
  - CFG_IDLE, port-2 write with rx_busy=0: config outputs update on the next edge.
  - CFG_IDLE, port-2 write with rx_busy=1: value latched into a shadow register; go to CFG_PEND.
  - CFG_PEND, further port-2 write: overwrites the shadow (last write wins).
  - CFG_PEND, first cycle with rx_busy=0: shadow copied to the outputs; go to CFG_IDLE.
  - Outputs therefore never change while rx_busy=1.
  - cfg_pend = (state == CFG_PEND).
- FIFO:
  - rx_done pushes rx_data in one cycle; the byte is readable the cycle after push.
  - Push when full with no pop: byte dropped, ovf set.
  - Push and pop in the same cycle when full: both happen, count unchanged, ovf not set.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo DEPTH; count width is AW+1.
- Sticky errors: rx_done with rx_perr sets perr; rx_done with rx_ferr sets ferr. Flags are set even if the byte is dropped.
- Set beats clear: if a status read coincides with a setting event, the flag remains 1.
- Interrupt FSM, states IRQ_IDLE, IRQ_ASSERT, IRQ_WAIT:
  - cause = (IE[0] & not_empty) | (IE[1] & (ovf | perr | ferr)).
  - IRQ_IDLE: cause=1 -> IRQ_ASSERT.
  - IRQ_ASSERT: INTERRUPT=1, held until interrupt_ack, then -> IRQ_WAIT.
  - IRQ_WAIT: INTERRUPT=0.
    - cause=0 -> IRQ_IDLE.
    - A new rx_done with cause still 1 -> IRQ_ASSERT.
  - interrupt_ack outside IRQ_ASSERT is ignored.
  - INTERRUPT is registered, asserted the cycle after entering IRQ_ASSERT.

Decomposition:
- Shared package uart_pkg:
  - port address constants (PORT_DATA=0, PORT_STAT=1, PORT_CFG=2, PORT_IE=3)
  - STATUS bit indices
  - reset config constants (CFG_BAUD_RST=4'b1000 etc.)
  - cfg and irq state encodings
- One sub-module, uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count and DEPTH parameter, no overflow logic inside.

Test Plan:
- Reset, then read ports 1/2/3 -> 8'h00, 8'h00, 8'h00; BAUD=8, EIGHT=1, PEN=0, OHEL=0.
- Write port 2 = 8'h65 with rx_busy=1 for 20 cycles -> STATUS=8'h20 and outputs unchanged; one cycle after rx_busy falls, BAUD=5, EIGHT=0, PEN=1, OHEL=1, cfg_pend=0.
- Push 8 bytes 8'h10..8'h17, then 9th 8'hAA -> STATUS=8'h07; port-0 reads return 8'h10..8'h17, then 8'h00; STATUS now 8'h04, then 8'h00 after that read clears ovf.
- With FIFO full, rx_done coincident with port-0 read_strobe -> no ovf, count stays 8, new byte read last.
- rx_done with rx_ferr=1 and IE=2'b10 -> INTERRUPT high next cycle; holds until interrupt_ack, then low; status read clears ferr and FSM returns to IRQ_IDLE.
- IE=2'b01, push one byte, ack without reading, then push a second byte -> INTERRUPT re-asserts after the second rx_done.
